// File: rtl/apb_2_pkg.sv
// Shared types and constants for the APB3 read-increment-write requester.
package apb_2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   localparam logic [1:0]  CMD_NOP   = 2'b00;
   localparam logic [1:0]  CMD_READ  = 2'b01;
   localparam logic [1:0]  CMD_WRITE = 2'b10;

   localparam logic [31:0] APB_ADDR  = 32'hDEAD_CAFE;

endpackage

// File: rtl/apb_2_master.sv
// APB3 requester: a read captures completer data, a write sends the captured value plus one
// back to the same fixed address.
module apb_2_master
   import apb_2_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  cmd_i,
   output logic        psel_o,
   output logic        penable_o,
   output logic [31:0] paddr_o,
   output logic        pwrite_o,
   output logic [31:0] pwdata_o,
   input  logic        pready_i,
   input  logic [31:0] prdata_i
);

   state_t      state_reg, state_next;
   logic [1:0]  cmd_reg, cmd_next;
   logic [31:0] rdata_reg, rdata_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cmd_reg   <= CMD_NOP;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cmd_reg   <= cmd_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cmd_next   = cmd_reg;
      rdata_next = rdata_reg;
      psel_o     = 1'b0;
      penable_o  = 1'b0;
      paddr_o    = '0;
      pwrite_o   = 1'b0;
      pwdata_o   = '0;

      case (state_reg)
         IDLE: begin
            // Reserved encoding 2'b11 is treated like a no-op.
            if (cmd_i == CMD_READ || cmd_i == CMD_WRITE) begin
               cmd_next   = cmd_i;
               state_next = SETUP;
            end
         end
         SETUP: begin
            psel_o     = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (pready_i) begin
               state_next = IDLE;
               if (cmd_reg == CMD_READ) begin
                  rdata_next = prdata_i;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Address, direction and data derive only from registers, so they hold for the whole transfer.
      if (state_reg != IDLE) begin
         paddr_o  = APB_ADDR;
         pwrite_o = (cmd_reg == CMD_WRITE);
         pwdata_o = (cmd_reg == CMD_WRITE) ? rdata_reg + 32'd1 : '0;
      end
   end

endmodule

// File: tb/tb_apb_2_master.sv
// Randomized scoreboard bench for apb_2_master: the driver queues expected transfers,
// a negedge monitor checks every bus cycle against the queue head.
module tb_apb_2_master;
   import apb_2_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  cmd_i = 2'b00;
   logic        psel_o, penable_o, pwrite_o;
   logic [31:0] paddr_o, pwdata_o;
   logic        pready_i = 1'b0;
   logic [31:0] prdata_i = '0;

   typedef struct {
      logic        pwrite;
      logic [31:0] wdata;
      int          len;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_rdata = '0;
   int          checks = 0;
   int          failures = 0;
   int          acc_cnt = 0;
   bit          prev_setup = 0;

   always #5 clk = ~clk;

   apb_2_master dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_i    (cmd_i),
      .psel_o   (psel_o),
      .penable_o(penable_o),
      .paddr_o  (paddr_o),
      .pwrite_o (pwrite_o),
      .pwdata_o (pwdata_o),
      .pready_i (pready_i),
      .prdata_i (prdata_i)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every negedge while out of reset, classify the bus cycle and compare.
   always @(negedge clk) begin
      if (!rst) begin
         acc_cnt    = 0;
         prev_setup = 0;
      end else if (psel_o && !penable_o) begin
         chk("setup_after_setup", {63'd0, prev_setup}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("spurious_transfer", 64'd1, 64'd0);
         end else begin
            chk("setup_pwrite", {63'd0, pwrite_o}, {63'd0, exp_q[0].pwrite});
            chk("setup_paddr", {32'd0, paddr_o}, {32'd0, APB_ADDR});
            chk("setup_pwdata", {32'd0, pwdata_o}, {32'd0, exp_q[0].wdata});
         end
         prev_setup = 1;
         acc_cnt    = 0;
      end else if (psel_o && penable_o) begin
         if (acc_cnt == 0) chk("access_without_setup", {63'd0, prev_setup}, 64'd1);
         acc_cnt++;
         if (exp_q.size() > 0) begin
            chk("access_pwrite", {63'd0, pwrite_o}, {63'd0, exp_q[0].pwrite});
            chk("access_paddr", {32'd0, paddr_o}, {32'd0, APB_ADDR});
            chk("access_pwdata", {32'd0, pwdata_o}, {32'd0, exp_q[0].wdata});
            if (pready_i) begin
               chk("access_len", 64'(acc_cnt), 64'(exp_q[0].len));
               void'(exp_q.pop_front());
               acc_cnt = 0;
            end
         end else begin
            chk("access_unexpected", 64'd1, 64'd0);
         end
         prev_setup = 0;
      end else begin
         chk("setup_to_access", {63'd0, prev_setup}, 64'd0);
         chk("idle_outputs", {30'd0, penable_o, pwrite_o, paddr_o}, 64'd0);
         chk("idle_pwdata", {32'd0, pwdata_o}, 64'd0);
         prev_setup = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transfer: issue in IDLE, random/forced cmd_i mid-transfer, `waits` stall cycles.
   task automatic do_xfer(input logic [1:0] cmd, input logic [31:0] rd, input int waits,
                          input bit force_write_mid);
      exp_t e;
      e.pwrite = (cmd == CMD_WRITE);
      e.wdata  = (cmd == CMD_WRITE) ? model_rdata + 32'd1 : 32'd0;
      e.len    = waits + 1;
      exp_q.push_back(e);
      if (cmd == CMD_READ) model_rdata = rd;
      cmd_i = cmd;
      step();
      chk("setup_latency", {62'd0, psel_o, penable_o}, 64'd2);
      cmd_i    = force_write_mid ? CMD_WRITE : 2'($urandom);
      pready_i = 1'($urandom);
      prdata_i = $urandom;
      step();
      for (int i = 0; i < waits; i++) begin
         cmd_i    = force_write_mid ? CMD_WRITE : 2'($urandom);
         pready_i = 1'b0;
         prdata_i = $urandom;
         step();
      end
      pready_i = 1'b1;
      prdata_i = rd;
      step();
      chk("back_to_idle", {63'd0, psel_o}, 64'd0);
      pready_i = 1'($urandom);
      prdata_i = $urandom;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_i    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         pready_i = 1'($urandom);
         prdata_i = $urandom;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with random command
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmd_i = 2'($urandom);
         step();
         chk("reset_outputs", {30'd0, psel_o, penable_o, pwrite_o, paddr_o[0]}, 64'd0);
         chk("reset_data", {paddr_o, pwdata_o}, 64'd0);
      end
      cmd_i = CMD_NOP;
      rst   = 1'b1;
      step();
      step();
      chk("post_reset_idle", {63'd0, psel_o}, 64'd0);

      // Write from reset sends 1
      do_xfer(CMD_WRITE, 32'd0, 0, 0);
      idle_cycles(1);

      // Read with wait states, then write
      do_xfer(CMD_READ, 32'h1234_5678, 3, 0);
      do_xfer(CMD_WRITE, 32'd0, 0, 0);
      idle_cycles(2);

      // Wrap
      do_xfer(CMD_READ, 32'hFFFF_FFFF, 0, 0);
      do_xfer(CMD_WRITE, 32'd0, 1, 0);

      // Command change mid-read; held write starts from next IDLE sample
      do_xfer(CMD_READ, 32'h0000_00A5, 2, 1);
      do_xfer(CMD_WRITE, 32'd0, 0, 0);
      idle_cycles(1);

      // Reset mid-transfer abandons the read
      begin
         exp_t e;
         e.pwrite = 1'b0;
         e.wdata  = 32'd0;
         e.len    = 99;
         exp_q.push_back(e);
         cmd_i = CMD_READ;
         step();
         pready_i = 1'b0;
         prdata_i = 32'h5555_AAAA;
         step();
         step();
         chk("mid_access", {62'd0, psel_o, penable_o}, 64'd3);
         #2;
         rst = 1'b0;
         #1;
         chk("async_drop", {62'd0, psel_o, penable_o}, 64'd0);
         void'(exp_q.pop_front());
         model_rdata = '0;
         pready_i    = 1'b1;
         step();
         cmd_i = CMD_NOP;
         step();
         rst = 1'b1;
         step();
         do_xfer(CMD_WRITE, 32'd0, 0, 0);
      end

      // Random traffic
      for (int n = 0; n < 40; n++) begin
         do_xfer(($urandom_range(0, 1) == 0) ? CMD_READ : CMD_WRITE, $urandom,
                 $urandom_range(0, 3), 0);
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(3);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
